bus_arbiter_nm: RTL and testbench
=================================

// Module: bus_arbiter_nm
// PURPOSE
//  N-master bus arbiter for the serial interconnect. Successor to the fixed 2-master arbiter.
//  Selects one bus owner among NUM_MASTERS requesters. Mode is round-robin or fixed priority.
//  Supports slave split transactions and a per-ownership hold timeout.
//  Drives the grants, the owner/slave select to the interconnect muxes, and the ARB/BUS busy flags.
// PARAMETERS
//  NUM_MASTERS  4   number of requesting masters (2..8)
//  NUM_SLAVES   3   number of valid slave indices (1..2**SLAVE_LEN)
//  SLAVE_LEN    2   width of each master's slave-select field
//  MAX_HOLD     255 max cycles in OWNED before forced release; 0 disables the timeout
//  HOLD_LEN     8   width of the hold counter; must satisfy MAX_HOLD < 2**HOLD_LEN
// PORTS
//  clk            in  1                      single clock, rising edge
//  rst            in  1                      asynchronous, active-low reset
//  prio_mode      in  1                      0 = round-robin, 1 = fixed priority (index 0 highest)
//  rqst           in  NUM_MASTERS            per-master bus request, level
//  slave_sel      in  NUM_MASTERS*SLAVE_LEN  master i target slave at [i*SLAVE_LEN +: SLAVE_LEN]
//  tx_done        in  1                      owner's transaction complete, 1-cycle pulse
//  split_req      in  1                      addressed slave requests split (bus release)
//  split_ready    in  NUM_SLAVES             slave s ready to resume its split transaction
//  grant          out NUM_MASTERS            one-hot ownership grant
//  owner          out $clog2(NUM_MASTERS)    index of current/last owner (mux select)
//  owner_slave    out SLAVE_LEN              latched slave index of owner (mux select)
//  arb_busy       out 1                      high in ARB state
//  bus_busy       out 1                      high in OWNED state
//  split_pending  out NUM_MASTERS            master i is parked on a split
//  timeout_err    out 1                      1-cycle pulse on forced release
//  sel_err        out 1                      1-cycle pulse when a winner candidate targets slave >= NUM_SLAVES
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE; grant, arb_busy, bus_busy, split_pending, timeout_err, sel_err all 0.
//   - owner=0, owner_slave=0, rr pointer=0, hold count=0.
//  Reset mid-transaction: all outputs drop immediately (asynchronously); no tx_done is required.
//  Eligibility: rqst[i] & ~split_pending[i] & (slave_sel_i < NUM_SLAVES).
//   - A request with slave_sel_i >= NUM_SLAVES is never granted.
//   - That request pulses sel_err once per IDLE evaluation in which it would otherwise have won.
//  Priority, highest first:
//   1. Resumed split masters, lowest index first.
//   2. prio_mode=0: round-robin from (rr_ptr+1) mod NUM_MASTERS upward with wrap.
//      prio_mode=1: lowest index first.
//  prio_mode is sampled only in IDLE.
//  FSM:
//   IDLE  -> ARB   if any eligible request; winner, owner and owner_slave are registered.
//   ARB   -> OWNED unconditionally. arb_busy=1, grant=0.
//            Winner is committed even if its rqst drops during ARB.
//   OWNED: grant[owner]=1, bus_busy=1. Hold counter increments each cycle from 0.
//    - tx_done            -> IDLE; rr_ptr<=owner.
//    - split_req (no done) -> IDLE; split_pending[owner]<=1; split slave recorded; rr_ptr<=owner.
//    - hold==MAX_HOLD (no done, MAX_HOLD!=0) -> IDLE; timeout_err pulse; rr_ptr<=owner.
//  Same-cycle precedence in OWNED: tx_done > split_req > timeout.
//  tx_done or split_req seen in IDLE/ARB: ignored.
//  Latency:
//   - rqst sampled in IDLE at cycle t: arb_busy=1 at t+1, grant=1 at t+2.
//   - tx_done at cycle k: grant=0 at k+1.
//   - Minimum 3 cycles from one grant rise to the next.
//  Split resume:
//   - split_ready[s] clears split_pending for every master parked on slave s.
//   - Those masters become "resumed" and carry top priority until their next grant.
//   - A resumed master still needs rqst=1 to win.
//   - split_ready for a slave with no parked master: no effect.
//   - split_ready arriving in the same cycle as split_req: the new split is recorded first.
//     The pending bit is cleared on the next cycle in which split_ready is seen.
//  Invariants: grant is one-hot or zero; grant!=0 iff bus_busy; arb_busy & bus_busy is never 1.
// TESTING
//  1. Reset, rqst=4'b0001, slave_sel0=1 -> arb_busy at t+1; grant=0001, owner_slave=1 at t+2;
//     tx_done -> grant=0 next cycle.
//  2. prio_mode=0, rqst=4'b1111 held, tx_done every 4th owned cycle -> grant order 1,2,3,0,1.
//     prio_mode=1 -> always 0001.
//  3. M2 owns slave 2, split_req pulse -> grant=0, split_pending=0100; M0 granted.
//     split_ready[2]=1 while M0 owns -> after M0 tx_done, M2 granted before M1/M3.
//  4. MAX_HOLD=5, owner never sends tx_done -> timeout_err pulse exactly after 6 OWNED cycles.
//     grant=0 next cycle; next RR master granted.
//  5. rqst=0010, slave_sel1=3, NUM_SLAVES=3 -> no grant, sel_err pulses;
//     tx_done+split_req in same OWNED cycle -> split_pending stays 0.
//  6. rst low during OWNED -> grant, bus_busy, split_pending=0 asynchronously;
//     after release, IDLE with rr_ptr=0.

Source files
------------

// File: rtl/bus_arbiter_nm_if.sv
// Bus-side signal bundle of the N-master arbiter: requests, split handshake,
// grants and the owner/slave mux selects.
interface bus_arbiter_nm_if #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned NUM_SLAVES  = 3,
  parameter int unsigned SLAVE_LEN   = 2
);
  localparam int unsigned OWNER_W = $clog2(NUM_MASTERS);

  logic                           prio_mode;
  logic [NUM_MASTERS-1:0]         rqst;
  logic [NUM_MASTERS*SLAVE_LEN-1:0] slave_sel;
  logic                           tx_done;
  logic                           split_req;
  logic [NUM_SLAVES-1:0]          split_ready;

  logic [NUM_MASTERS-1:0]         grant;
  logic [OWNER_W-1:0]             owner;
  logic [SLAVE_LEN-1:0]           owner_slave;
  logic                           arb_busy;
  logic                           bus_busy;
  logic [NUM_MASTERS-1:0]         split_pending;
  logic                           timeout_err;
  logic                           sel_err;

  // master: the requesting side of the interconnect; slave: the arbiter itself
  modport master (
    output prio_mode, rqst, slave_sel, tx_done, split_req, split_ready,
    input  grant, owner, owner_slave, arb_busy, bus_busy, split_pending,
           timeout_err, sel_err
  );

  modport slave (
    input  prio_mode, rqst, slave_sel, tx_done, split_req, split_ready,
    output grant, owner, owner_slave, arb_busy, bus_busy, split_pending,
           timeout_err, sel_err
  );
endinterface

// File: rtl/bus_arbiter_nm.sv
// N-master bus arbiter: round-robin or fixed priority, slave split
// transactions with resume priority, and a per-ownership hold timeout.
module bus_arbiter_nm #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned NUM_SLAVES  = 3,
  parameter int unsigned SLAVE_LEN   = 2,
  parameter int unsigned MAX_HOLD    = 255,
  parameter int unsigned HOLD_LEN    = 8
) (
  input logic             clk,
  input logic             rst,
  bus_arbiter_nm_if.slave bus
);
  localparam int unsigned OWNER_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, ARB, OWNED} state_t;

  state_t                 state;
  logic [NUM_MASTERS-1:0] grant, split_pending, resumed;
  logic [OWNER_W-1:0]     owner, rr_ptr;
  logic [SLAVE_LEN-1:0]   owner_slave;
  logic [SLAVE_LEN-1:0]   split_slave [NUM_MASTERS];
  logic [HOLD_LEN-1:0]    hold_cnt;
  logic                   arb_busy, bus_busy, timeout_err, sel_err;

  logic [SLAVE_LEN-1:0]   sel_f [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] sel_ok, ready_hit, cand_raw, cand_ok;
  logic                   raw_found, win_found;
  logic [OWNER_W-1:0]     raw_idx, win_idx;
  logic [SLAVE_LEN-1:0]   win_sel;

  function automatic logic [OWNER_W:0] scan(input logic [NUM_MASTERS-1:0] v,
                                            input int unsigned start);
    logic [OWNER_W:0] r;
    r = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      logic [OWNER_W-1:0] j;
      j = OWNER_W'((start + k) % NUM_MASTERS);
      if (!r[OWNER_W] && v[j]) r = {1'b1, j};
    end
    return r;
  endfunction

  function automatic logic [OWNER_W:0] pick(input logic [NUM_MASTERS-1:0] v,
                                            input logic [NUM_MASTERS-1:0] res_v,
                                            input logic                   fixed,
                                            input logic [OWNER_W-1:0]     ptr);
    if ((v & res_v) != '0) return scan(v & res_v, 0);
    if (fixed) return scan(v, 0);
    return scan(v, 32'(ptr) + 32'd1);
  endfunction

  // Two picks: the unfiltered one finds the would-be winner for sel_err,
  // the filtered one the actual winner.
  always_comb begin
    sel_ok    = '0;
    ready_hit = '0;
    win_sel   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      sel_f[i]  = bus.slave_sel[i*SLAVE_LEN +: SLAVE_LEN];
      sel_ok[i] = {1'b0, sel_f[i]} < (SLAVE_LEN+1)'(NUM_SLAVES);
      for (int unsigned s = 0; s < NUM_SLAVES; s++)
        if (split_pending[i] && bus.split_ready[s] && split_slave[i] == SLAVE_LEN'(s))
          ready_hit[i] = 1'b1;
    end
    cand_raw = bus.rqst & ~split_pending;
    cand_ok  = cand_raw & sel_ok;
    {raw_found, raw_idx} = pick(cand_raw, resumed, bus.prio_mode, rr_ptr);
    {win_found, win_idx} = pick(cand_ok, resumed, bus.prio_mode, rr_ptr);
    for (int unsigned i = 0; i < NUM_MASTERS; i++)
      if (OWNER_W'(i) == win_idx) win_sel = sel_f[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      grant         <= '0;
      owner         <= '0;
      owner_slave   <= '0;
      rr_ptr        <= '0;
      hold_cnt      <= '0;
      arb_busy      <= 1'b0;
      bus_busy      <= 1'b0;
      split_pending <= '0;
      resumed       <= '0;
      timeout_err   <= 1'b0;
      sel_err       <= 1'b0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) split_slave[i] <= '0;
    end else begin
      timeout_err <= 1'b0;
      sel_err     <= 1'b0;
      // A split recorded below in OWNED overrides a same-cycle resume.
      for (int unsigned i = 0; i < NUM_MASTERS; i++)
        if (ready_hit[i]) begin
          split_pending[i] <= 1'b0;
          resumed[i]       <= 1'b1;
        end
      unique case (state)
        IDLE: begin
          sel_err <= raw_found && !sel_ok[raw_idx];
          if (win_found) begin
            state            <= ARB;
            arb_busy         <= 1'b1;
            owner            <= win_idx;
            owner_slave      <= win_sel;
            resumed[win_idx] <= 1'b0;
          end
        end
        ARB: begin
          state    <= OWNED;
          arb_busy <= 1'b0;
          bus_busy <= 1'b1;
          grant    <= NUM_MASTERS'(1) << owner;
          hold_cnt <= '0;
        end
        OWNED: begin
          hold_cnt <= hold_cnt + HOLD_LEN'(1);
          if (bus.tx_done || bus.split_req ||
              (MAX_HOLD != 0 && hold_cnt == HOLD_LEN'(MAX_HOLD))) begin
            state    <= IDLE;
            grant    <= '0;
            bus_busy <= 1'b0;
            rr_ptr   <= owner;
            if (!bus.tx_done && bus.split_req) begin
              split_pending[owner] <= 1'b1;
              split_slave[owner]   <= owner_slave;
            end else if (!bus.tx_done) begin
              timeout_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant         = grant;
  assign bus.owner         = owner;
  assign bus.owner_slave   = owner_slave;
  assign bus.arb_busy      = arb_busy;
  assign bus.bus_busy      = bus_busy;
  assign bus.split_pending = split_pending;
  assign bus.timeout_err   = timeout_err;
  assign bus.sel_err       = sel_err;
endmodule

// File: tb/tb_bus_arbiter_nm.sv
// Directed bench for bus_arbiter_nm (4 masters, 3 slaves, MAX_HOLD=5); expected
// grants are queued as stimulus is applied and popped when a grant appears.
module tb_bus_arbiter_nm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  bus_arbiter_nm_if #(.NUM_MASTERS(4), .NUM_SLAVES(3), .SLAVE_LEN(2)) bus_if ();

  bus_arbiter_nm #(
    .NUM_MASTERS(4), .NUM_SLAVES(3), .SLAVE_LEN(2), .MAX_HOLD(5), .HOLD_LEN(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input string tag);
    logic [3:0] exp;
    int unsigned n;
    n = 0;
    while (bus_if.grant == '0 && n < 20) begin
      tick();
      n++;
    end
    exp = (exp_q.size() == 0) ? 4'b0000 : exp_q.pop_front();
    check(tag, 32'(bus_if.grant), 32'(exp));
  endtask

  task automatic finish_tx(input int unsigned owned_cycles);
    repeat (owned_cycles - 1) tick();
    bus_if.tx_done = 1'b1;
    tick();
    bus_if.tx_done = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.prio_mode   = 1'b0;
    bus_if.rqst        = '0;
    bus_if.slave_sel   = '0;
    bus_if.tx_done     = 1'b0;
    bus_if.split_req   = 1'b0;
    bus_if.split_ready = '0;

    // reset state
    #12;
    check("rst_grant", 32'(bus_if.grant), 0);
    check("rst_owner", 32'(bus_if.owner), 0);
    check("rst_owner_slave", 32'(bus_if.owner_slave), 0);
    check("rst_busy", 32'({bus_if.arb_busy, bus_if.bus_busy}), 0);
    check("rst_split_pending", 32'(bus_if.split_pending), 0);
    check("rst_errs", 32'({bus_if.timeout_err, bus_if.sel_err}), 0);
    rst = 1'b1;
    tick();

    // single request latency
    bus_if.rqst      = 4'b0001;
    bus_if.slave_sel = 8'b00_00_00_01;
    tick();
    check("lat_arb_busy", 32'(bus_if.arb_busy), 1);
    check("lat_no_grant_in_arb", 32'(bus_if.grant), 0);
    exp_q.push_back(4'b0001);
    tick();
    wait_grant("lat_grant");
    check("lat_owner_slave", 32'(bus_if.owner_slave), 1);
    check("lat_busy_flags", 32'({bus_if.arb_busy, bus_if.bus_busy}), 1);
    bus_if.tx_done = 1'b1;
    bus_if.rqst    = '0;
    tick();
    bus_if.tx_done = 1'b0;
    check("lat_release", 32'({bus_if.grant, bus_if.bus_busy}), 0);

    // round-robin then fixed priority, all requesting
    bus_if.rqst      = 4'b1111;
    bus_if.slave_sel = '0;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    for (int i = 0; i < 5; i++) begin
      wait_grant("rr_order");
      finish_tx(4);
    end
    bus_if.prio_mode = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(4'b0001);
    for (int i = 0; i < 3; i++) begin
      wait_grant("fixed_order");
      finish_tx(4);
    end
    bus_if.rqst = '0;

    // split: M2 parks on slave 2, M0 runs, M2 resumes ahead of M1/M3
    bus_if.rqst      = 4'b0100;
    bus_if.slave_sel = 8'b00_10_01_00;
    exp_q.push_back(4'b0100);
    wait_grant("split_m2_grant");
    check("split_m2_owner", 32'(bus_if.owner), 2);
    check("split_m2_slave", 32'(bus_if.owner_slave), 2);
    bus_if.rqst      = 4'b1111;
    bus_if.split_req = 1'b1;
    tick();
    bus_if.split_req = 1'b0;
    check("split_release", 32'(bus_if.grant), 0);
    check("split_pending_set", 32'(bus_if.split_pending), 32'h4);
    exp_q.push_back(4'b0001);
    wait_grant("split_m0_grant");
    bus_if.split_ready = 3'b100;
    tick();
    bus_if.split_ready = '0;
    check("split_ready_clear", 32'(bus_if.split_pending), 0);
    finish_tx(1);
    exp_q.push_back(4'b0100);
    wait_grant("split_resume_first");
    finish_tx(1);
    bus_if.rqst = '0;

    // split_ready coinciding with split_req, and for an unrelated slave
    bus_if.rqst = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_grant("same_cycle_grant");
    bus_if.split_req   = 1'b1;
    bus_if.split_ready = 3'b100;
    tick();
    bus_if.split_req   = 1'b0;
    bus_if.split_ready = 3'b001;
    check("same_cycle_recorded", 32'(bus_if.split_pending), 32'h4);
    tick();
    check("ready_other_slave", 32'(bus_if.split_pending), 32'h4);
    bus_if.split_ready = 3'b100;
    tick();
    bus_if.split_ready = '0;
    check("later_ready_clear", 32'(bus_if.split_pending), 0);
    exp_q.push_back(4'b0100);
    wait_grant("same_cycle_resume");
    finish_tx(1);
    bus_if.rqst = '0;

    // hold timeout, rr_ptr=2 so M3 owns first
    bus_if.prio_mode = 1'b0;
    bus_if.rqst      = 4'b1111;
    exp_q.push_back(4'b1000);
    wait_grant("to_grant");
    repeat (5) tick();
    check("to_still_owned", 32'({bus_if.timeout_err, bus_if.grant}), 32'h08);
    tick();
    check("to_pulse", 32'({bus_if.timeout_err, bus_if.grant}), 32'h10);
    exp_q.push_back(4'b0001);
    tick();
    check("to_pulse_end", 32'(bus_if.timeout_err), 0);
    wait_grant("to_next_rr");
    finish_tx(1);
    bus_if.rqst = '0;

    // invalid slave select
    bus_if.rqst      = 4'b0010;
    bus_if.slave_sel = 8'b00_10_11_00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sel_err_pulse", 32'(bus_if.sel_err), 1);
      check("sel_err_no_arb", 32'({bus_if.grant, bus_if.arb_busy}), 0);
    end
    bus_if.rqst = '0;
    tick();
    check("sel_err_clear", 32'(bus_if.sel_err), 0);
    bus_if.rqst = 4'b0110;
    tick();
    check("sel_err_skip", 32'({bus_if.sel_err, bus_if.arb_busy}), 3);
    exp_q.push_back(4'b0100);
    wait_grant("sel_err_alt_grant");
    bus_if.tx_done   = 1'b1;
    bus_if.split_req = 1'b1;
    bus_if.rqst      = '0;
    tick();
    bus_if.tx_done   = 1'b0;
    bus_if.split_req = 1'b0;
    check("done_beats_split_grant", 32'(bus_if.grant), 0);
    check("done_beats_split_pend", 32'(bus_if.split_pending), 0);

    // asynchronous reset while owned with a parked split
    bus_if.prio_mode = 1'b1;
    bus_if.slave_sel = 8'b00_10_01_00;
    bus_if.rqst      = 4'b0011;
    exp_q.push_back(4'b0001);
    wait_grant("ar_m0_grant");
    bus_if.split_req = 1'b1;
    tick();
    bus_if.split_req = 1'b0;
    check("ar_pending", 32'(bus_if.split_pending), 32'h1);
    exp_q.push_back(4'b0010);
    wait_grant("ar_m1_grant");
    #2 rst = 1'b0;
    #1;
    check("ar_grant_drop", 32'({bus_if.grant, bus_if.bus_busy}), 0);
    check("ar_pending_drop", 32'(bus_if.split_pending), 0);
    check("ar_owner_zero", 32'(bus_if.owner), 0);
    bus_if.prio_mode = 1'b0;
    bus_if.rqst      = 4'b1111;
    #3 rst = 1'b1;
    tick();
    check("ar_rearb", 32'(bus_if.arb_busy), 1);
    exp_q.push_back(4'b0010);
    wait_grant("ar_rr_from_zero");
    bus_if.rqst = '0;
    finish_tx(1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
